apb_uart_v2: RTL and testbench



---
 rtl/apb_uart_v2.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_apb_uart_v2.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/apb_uart_v2.sv
// apb_uart_v2: APB UART with programmable baud divisor, optional parity,
// one/two stop bits, TX/RX FIFOs, sticky error flags and a level interrupt.

// Synchronous FIFO; a push into a full FIFO is ignored even when a pop
// happens in the same cycle (full is judged on the pre-pop count).
module apb_uart_v2_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write port; contents need no reset
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end
endmodule

module apb_uart_v2 #(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_BITS  = 8,
    parameter int DIV_RESET  = 651
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [3:0]  PADDR,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        tx,
    input  logic        rx,
    output logic        irq
);
    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    // ---------------- APB decode ----------------
    logic       access, wr_en, rd_en;
    logic [1:0] reg_sel;
    logic       ctrl_wr, status_wr, tx_wr, rx_rd;

    assign access    = PSEL & PENABLE;
    assign PREADY    = access;
    assign wr_en     = access & PWRITE;
    assign rd_en     = access & ~PWRITE;
    assign reg_sel   = PADDR[3:2];
    assign ctrl_wr   = wr_en & (reg_sel == 2'd1);
    assign status_wr = wr_en & (reg_sel == 2'd0);
    assign tx_wr     = wr_en & (reg_sel == 2'd2);
    assign rx_rd     = rd_en & (reg_sel == 2'd3);

    logic unused_bits;
    assign unused_bits = ^{PADDR[1:0], PWDATA[31:21]};

    // ---------------- CTRL ----------------
    logic [20:0] ctrl_q;
    logic [15:0] div;
    logic        par_en, par_odd, two_stop, rx_ie, tx_ie;

    assign div      = ctrl_q[15:0];
    assign par_en   = ctrl_q[16];
    assign par_odd  = ctrl_q[17];
    assign two_stop = ctrl_q[18];
    assign rx_ie    = ctrl_q[19];
    assign tx_ie    = ctrl_q[20];

    // Control register, written whole on a CTRL access
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)       ctrl_q <= {5'b0, 16'(DIV_RESET)};
        else if (ctrl_wr) ctrl_q <= PWDATA[20:0];
    end

    // ---------------- Baud tick ----------------
    logic [15:0] baud_cnt, div_eff;
    logic        tick;

    assign div_eff = (div == 16'd0) ? 16'd1 : div;
    assign tick    = (baud_cnt == div_eff - 16'd1);

    // Free-running divider; restarted on CTRL writes so a new DIV takes effect cleanly
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)                baud_cnt <= '0;
        else if (ctrl_wr || tick)  baud_cnt <= '0;
        else                       baud_cnt <= baud_cnt + 16'd1;
    end

    // ---------------- FIFOs ----------------
    logic [DATA_BITS-1:0] tx_head, rx_head, rx_shift;
    logic                 tx_empty, tx_full, rx_empty, rx_full;
    logic                 tx_pop, rx_push;

    apb_uart_v2_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_tx_fifo (
        .clk(PCLK), .rst(PRESET), .push(tx_wr), .pop(tx_pop),
        .wdata(PWDATA[DATA_BITS-1:0]), .rdata(tx_head),
        .empty(tx_empty), .full(tx_full)
    );

    apb_uart_v2_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_rx_fifo (
        .clk(PCLK), .rst(PRESET), .push(rx_push), .pop(rx_rd),
        .wdata(rx_shift), .rdata(rx_head),
        .empty(rx_empty), .full(rx_full)
    );

    // ---------------- TX engine ----------------
    state_t               tx_state, tx_next;
    logic [4:0]           tx_cnt;
    logic [2:0]           tx_idx;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par_bit, tx_bit_end, tx_stop_end, tx_busy, tx_line;

    // Bits last 16 ticks; the 5-bit counter's low nibble marks each bit end,
    // the full count marks the end of a double stop bit
    assign tx_bit_end  = tick & (tx_cnt[3:0] == 4'd15);
    assign tx_stop_end = two_stop ? (tick & (tx_cnt == 5'd31)) : tx_bit_end;
    assign tx_busy     = (tx_state != S_IDLE);

    // TX state register
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) tx_state <= S_IDLE;
        else        tx_state <= tx_next;
    end

    // TX next-state and FIFO pop
    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        case (tx_state)
            S_IDLE:  if (!tx_empty) begin
                         tx_pop  = 1'b1;
                         tx_next = S_START;
                     end
            S_START: if (tx_bit_end) tx_next = S_DATA;
            S_DATA:  if (tx_bit_end && tx_idx == LAST_IDX) tx_next = par_en ? S_PAR : S_STOP;
            S_PAR:   if (tx_bit_end) tx_next = S_STOP;
            S_STOP:  if (tx_stop_end) tx_next = S_IDLE;
            default: tx_next = S_IDLE;
        endcase
    end

    // Line level for the current state; registered below so tx is glitch-free
    always_comb begin
        tx_line = 1'b1;
        case (tx_state)
            S_START: tx_line = 1'b0;
            S_DATA:  tx_line = tx_shift[0];
            S_PAR:   tx_line = tx_par_bit;
            default: tx_line = 1'b1;
        endcase
    end

    // TX datapath: tick counter, shift register, latched parity, output flop
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tx_cnt     <= '0;
            tx_idx     <= '0;
            tx_shift   <= '0;
            tx_par_bit <= 1'b0;
            tx         <= 1'b1;
        end else begin
            tx <= tx_line;
            if (tx_state == S_IDLE || tx_next != tx_state) tx_cnt <= '0;
            else if (tick)                                 tx_cnt <= tx_cnt + 5'd1;
            if (tx_pop) begin
                tx_shift   <= tx_head;
                tx_idx     <= '0;
                tx_par_bit <= (^tx_head) ^ par_odd;
            end else if (tx_state == S_DATA && tx_bit_end) begin
                tx_shift <= tx_shift >> 1;
                tx_idx   <= tx_idx + 3'd1;
            end
        end
    end

    // ---------------- RX engine ----------------
    state_t     rx_state, rx_next;
    logic [1:0] rx_sync;
    logic       rx_s, rx_prev, rx_fall, rx_sample, rx_par_bit;
    logic [3:0] rx_cnt;
    logic [2:0] rx_idx;

    assign rx_s      = rx_sync[1];
    assign rx_fall   = rx_prev & ~rx_s;
    assign rx_sample = tick & (rx_cnt == 4'd15);

    // Two-flop synchroniser plus edge-detect history
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], rx};
            rx_prev <= rx_s;
        end
    end

    // RX state register
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) rx_state <= S_IDLE;
        else        rx_state <= rx_next;
    end

    // RX next-state; mid-start check rejects glitches, stop sample pushes
    always_comb begin
        rx_next = rx_state;
        rx_push = 1'b0;
        case (rx_state)
            S_IDLE:  if (rx_fall) rx_next = S_START;
            S_START: if (tick && rx_cnt == 4'd7) rx_next = rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (rx_sample && rx_idx == LAST_IDX) rx_next = par_en ? S_PAR : S_STOP;
            S_PAR:   if (rx_sample) rx_next = S_STOP;
            S_STOP:  if (rx_sample) begin
                         rx_push = 1'b1;
                         rx_next = S_IDLE;
                     end
            default: rx_next = S_IDLE;
        endcase
    end

    // RX datapath: the 4-bit counter wraps every 16 ticks, giving the sample spacing
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_shift   <= '0;
            rx_par_bit <= 1'b0;
        end else begin
            if (rx_state == S_IDLE || rx_next != rx_state) rx_cnt <= '0;
            else if (tick)                                 rx_cnt <= rx_cnt + 4'd1;
            if (rx_state == S_IDLE) rx_idx <= '0;
            if (rx_state == S_DATA && rx_sample) begin
                rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
                rx_idx   <= rx_idx + 3'd1;
            end
            if (rx_state == S_PAR && rx_sample) rx_par_bit <= rx_s;
        end
    end

    // ---------------- Sticky flags ----------------
    logic [3:0] flags, flag_set, flag_clr;
    logic       parity_err, frame_err, rx_overrun, tx_drop;

    assign {tx_drop, rx_overrun, frame_err, parity_err} = flags;
    assign flag_set = {tx_wr & tx_full,
                       rx_push & rx_full,
                       rx_push & ~rx_s,
                       rx_push & par_en & (rx_par_bit != ((^rx_shift) ^ par_odd))};
    assign flag_clr = status_wr ? PWDATA[7:4] : 4'b0;

    // Write-1-to-clear flags; a same-cycle event wins over the clear
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) flags <= '0;
        else        flags <= flag_set | (flags & ~flag_clr);
    end

    // ---------------- Read mux and interrupt ----------------
    // Read data is driven only during the access phase of a read
    always_comb begin
        PRDATA = '0;
        if (rd_en) begin
            case (reg_sel)
                2'd0:    PRDATA = {24'b0, flags, rx_full, tx_full, rx_empty, tx_busy};
                2'd1:    PRDATA = {11'b0, ctrl_q};
                2'd3:    PRDATA = rx_empty ? 32'd0 : {{(32-DATA_BITS){1'b0}}, rx_head};
                default: PRDATA = '0;
            endcase
        end
    end

    assign irq = (rx_ie & (~rx_empty | parity_err | frame_err | rx_overrun)) |
                 (tx_ie & tx_empty & ~tx_busy);
endmodule

// File: tb/tb_apb_uart_v2.sv
// Directed testbench for apb_uart_v2: reset state, TX framing, TX FIFO drop,
// RX parity/frame errors, glitch rejection and RX overrun.
module tb_apb_uart_v2;
    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic [3:0]  PADDR = '0;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        tx;
    logic        rx = 1'b1;
    logic        irq;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] rdata;
    logic        last_ready;

    localparam int BIT_CYC = 64;  // 16 ticks * DIV=4

    apb_uart_v2 dut (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .tx(tx), .rx(rx), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    // Returns 1 time unit after the edge that completes the access
    task automatic apb_write(input logic [3:0] addr, input logic [31:0] data);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] addr, output logic [31:0] data);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        data = PRDATA;
        last_ready = PREADY;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // 8-bit frame at DIV=4, optional parity bit, chosen stop level
    task automatic send_frame(input logic [7:0] d, input logic use_par,
                              input logic par_bit, input logic stop_bit);
        rx = 1'b0;
        wait_cyc(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_cyc(BIT_CYC);
        end
        if (use_par) begin
            rx = par_bit;
            wait_cyc(BIT_CYC);
        end
        rx = stop_bit;
        wait_cyc(BIT_CYC);
        rx = 1'b1;
    endtask

    initial begin
        logic [7:0] a5;
        a5 = 8'hA5;

        // ---- reset state ----
        wait_cyc(3);
        PRESET = 1'b0;
        chk("reset_tx", tx, 1'b1);
        chk("reset_irq", irq, 1'b0);
        chk("reset_prdata_idle", PRDATA, 32'h0);
        apb_read(4'h4, rdata);
        chk("reset_ctrl", rdata, 32'h0000_028B);
        chk("pready_access", last_ready, 1'b1);
        apb_read(4'h0, rdata);
        chk("reset_status", rdata, 32'h02);

        // ---- TX 0xA5, DIV=4, 8N1 ----
        apb_write(4'h4, 32'h4);
        apb_write(4'h8, 32'hA5);         // write edge W
        wait_cyc(1);
        chk("tx_w_plus1_high", tx, 1'b1);
        wait_cyc(1);
        chk("tx_w_plus2_start", tx, 1'b0);
        wait_cyc(94);                     // mid data bit 0
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("tx_bit%0d", i), tx, a5[i]);
            wait_cyc(BIT_CYC);
        end
        chk("tx_stop", tx, 1'b1);
        wait_cyc(20);
        apb_read(4'h0, rdata);            // observes state at W+630
        chk("tx_busy_near_end", rdata, 32'h03);
        wait_cyc(12);
        apb_read(4'h0, rdata);            // observes state at W+645
        chk("tx_busy_cleared", rdata, 32'h02);

        // ---- TX FIFO full / drop, DIV=0xFFFF ----
        apb_write(4'h4, 32'hFFFF);
        for (int i = 0; i < 17; i++) apb_write(4'h8, 32'(i));
        apb_read(4'h0, rdata);
        chk("tx_full_after17", rdata, 32'h07);
        chk("tx_start_bit_stalled", tx, 1'b0);
        apb_write(4'h8, 32'h55);
        apb_read(4'h0, rdata);
        chk("tx_drop_set", rdata, 32'h87);
        apb_write(4'h0, 32'h80);
        apb_read(4'h0, rdata);
        chk("tx_drop_w1c", rdata, 32'h07);

        // ---- reset mid-frame: tx released without a clock edge ----
        #2 PRESET = 1'b1;
        #1;
        chk("async_reset_tx", tx, 1'b1);
        wait_cyc(2);
        PRESET = 1'b0;
        apb_read(4'h0, rdata);
        chk("post_reset_status", rdata, 32'h02);

        // ---- RX 0x3C with wrong even parity, rx_ie=1 ----
        apb_write(4'h4, 32'h0009_0004);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        wait_cyc(10);
        chk("par_irq_set", irq, 1'b1);
        apb_read(4'h0, rdata);
        chk("par_status", rdata, 32'h10);
        apb_read(4'hC, rdata);
        chk("par_rxdata", rdata, 32'h3C);
        chk("par_irq_after_read", irq, 1'b1);
        apb_write(4'h0, 32'h10);
        chk("par_irq_cleared", irq, 1'b0);
        apb_read(4'h0, rdata);
        chk("par_status_cleared", rdata, 32'h02);

        // ---- glitch rejection, then frame error ----
        apb_write(4'h4, 32'h4);
        rx = 1'b0;
        wait_cyc(20);
        rx = 1'b1;
        wait_cyc(100);
        apb_read(4'h0, rdata);
        chk("glitch_no_byte", rdata, 32'h02);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        wait_cyc(10);
        apb_read(4'h0, rdata);
        chk("frame_err_status", rdata, 32'h20);
        apb_read(4'hC, rdata);
        chk("frame_err_rxdata", rdata, 32'h5A);
        apb_write(4'h0, 32'h20);
        apb_read(4'h0, rdata);
        chk("frame_err_cleared", rdata, 32'h02);

        // ---- RX overrun: 17 frames, no reads ----
        for (int i = 1; i <= 17; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b1);
        wait_cyc(10);
        apb_read(4'h0, rdata);
        chk("overrun_status", rdata, 32'h48);
        for (int i = 1; i <= 16; i++) begin
            apb_read(4'hC, rdata);
            chk($sformatf("overrun_read%0d", i), rdata, 32'(i));
        end
        apb_read(4'hC, rdata);
        chk("empty_read_zero", rdata, 32'h0);
        apb_read(4'h0, rdata);
        chk("overrun_sticky", rdata, 32'h42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
